// File: rtl/mem_if_pkg.sv
// Shared definitions for the load/store memory access path.
// Contents:
//   state_e        - sequencing states of the access unit
//   MEM_BYTES_DEF  - default number of implemented data-memory bytes
//   size_e         - access-size encoding (word / byte)
//   extend_load    - formats raw memory read data into a load result
package mem_if_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      ACCESS  = 3'd2,
      RELEASE = 3'd3,
      RESP    = 3'd4
   } state_e;

   localparam int MEM_BYTES_DEF = 128;

   typedef enum logic {
      SIZE_WORD = 1'b0,
      SIZE_BYTE = 1'b1
   } size_e;

   // Byte loads use only the low byte of the memory word; word loads pass through.
   function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                               input size_e       size,
                                               input logic        is_signed);
      logic [31:0] result;
      if (size == SIZE_WORD) begin
         result = raw;
      end else if (is_signed) begin
         result = {{24{raw[7]}}, raw[7:0]};
      end else begin
         result = {24'd0, raw[7:0]};
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational legality check for a data or instruction memory access.
// Ports:
//   addr  in  ADDR_W  byte address of the access
//   size  in  size_e  word or byte access
//   error out 1       access falls outside memory or is a misaligned word
module mem_access_check
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int MEM_BYTES   = MEM_BYTES_DEF,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic [ADDR_W-1:0] addr,
   input  size_e             size,
   output logic              error
);

   // One extra bit so addr+3 cannot wrap back into range near the top of the address space.
   localparam int EXT_W = ADDR_W + 1;

   logic [EXT_W-1:0] last_byte;
   logic             out_of_range;
   logic             misaligned;

   always_comb begin
      last_byte    = {1'b0, addr} + ((size == SIZE_BYTE) ? EXT_W'(0) : EXT_W'(3));
      out_of_range = (last_byte >= EXT_W'(MEM_BYTES));
      misaligned   = ALIGN_CHECK && (size == SIZE_WORD) && (addr[1:0] != 2'b00);
      error        = out_of_range || misaligned;
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, and req_* are ignored in every other state.
// The response is a single-cycle resp_valid pulse with resp_rdata/resp_error,
// which then hold until the next response.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_write/req_byte/req_signed/req_addr/req_wdata  request fields
//   resp_valid/resp_rdata/resp_error                 response
//   byteOperations/address/write_data/memRead/memWrite  registered memory strobes
//   read_data             memory read data
//   dbg_state             current sequencing state
module mem_access_unit
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = 18,
   parameter int MEM_BYTES   = MEM_BYTES_DEF,
   parameter int READ_HOLD   = 1,
   parameter int WRITE_HOLD  = 1,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic              byteOperations,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       write_data,
   output logic              memRead,
   output logic              memWrite,
   input  logic [31:0]       read_data,
   output state_e            dbg_state
);

   localparam int MAX_HOLD = (READ_HOLD > WRITE_HOLD) ? READ_HOLD : WRITE_HOLD;
   localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_HOLD - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_HOLD - 1);

   state_e           state;
   state_e           next_state;
   logic [CNT_W-1:0] hold_cnt;
   logic             write_q;
   logic             signed_q;
   logic             req_error;
   logic             accept;
   logic             last_access;

   mem_access_check #(
      .ADDR_W      (ADDR_W),
      .MEM_BYTES   (MEM_BYTES),
      .ALIGN_CHECK (ALIGN_CHECK)
   ) u_check (
      .addr  (req_addr),
      .size  (size_e'(req_byte)),
      .error (req_error)
   );

   assign accept      = req_valid && (state == IDLE);
   assign last_access = (state == ACCESS) && (hold_cnt == '0);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = req_error ? RESP : SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (hold_cnt == '0) next_state = write_q ? RELEASE : RESP;
         RELEASE: next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      dbg_state  = state;
   end

   // Memory-side registers, hold counter and response data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         address        <= '0;
         write_data     <= '0;
         byteOperations <= 1'b0;
         memRead        <= 1'b0;
         memWrite       <= 1'b0;
         write_q        <= 1'b0;
         signed_q       <= 1'b0;
         hold_cnt       <= '0;
         resp_rdata     <= '0;
         resp_error     <= 1'b0;
      end else begin
         // Address/data load only for legal accesses so they are stable from SETUP
         // through RELEASE; a rejected request never touches the memory side.
         if (accept && !req_error) begin
            address        <= req_addr;
            write_data     <= req_wdata;
            byteOperations <= req_byte;
            write_q        <= req_write;
            signed_q       <= req_signed;
         end

         // Strobes are registered from next_state so they rise entering ACCESS
         // and fall on the edge that leaves it.
         memRead  <= (next_state == ACCESS) && !write_q;
         memWrite <= (next_state == ACCESS) &&  write_q;

         if (state == SETUP) begin
            hold_cnt <= write_q ? WR_LOAD : RD_LOAD;
         end else if ((state == ACCESS) && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
         end

         if (accept && req_error) begin
            resp_rdata <= '0;
            resp_error <= 1'b1;
         end else if (last_access && !write_q) begin
            resp_rdata <= extend_load(read_data, size_e'(byteOperations), signed_q);
            resp_error <= 1'b0;
         end else if (state == RELEASE) begin
            resp_rdata <= '0;
            resp_error <= 1'b0;
         end
      end
   end

   a_strobe_exclusive : assert property (@(posedge clk) disable iff (reset)
      !(memRead && memWrite));

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed requests, a transaction-level model of the
// expected cycle timeline, a per-cycle compare process, and literal expectations.
module tb_mem_access_unit;
   import mem_if_pkg::*;

   localparam int AW = 18;
   localparam int MB = 128;
   localparam int RH = 1;
   localparam int WH = 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic          req_byte;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_error;
   logic          byteOperations;
   logic [AW-1:0] address;
   logic [31:0]   write_data;
   logic          memRead;
   logic          memWrite;
   logic [31:0]   read_data;
   state_e        dbg_state;

   int n_vec = 0;
   int n_err = 0;

   mem_access_unit #(
      .ADDR_W      (AW),
      .MEM_BYTES   (MB),
      .READ_HOLD   (RH),
      .WRITE_HOLD  (WH),
      .ALIGN_CHECK (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_byte       (req_byte),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_error     (resp_error),
      .byteOperations (byteOperations),
      .address        (address),
      .write_data     (write_data),
      .memRead        (memRead),
      .memWrite       (memWrite),
      .read_data      (read_data),
      .dbg_state      (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: m_k counts cycles since acceptance, m_len is the
   // cycle in which the response appears.
   logic          m_active;
   int            m_k;
   int            m_len;
   logic          m_err;
   logic          m_w;
   logic          m_b;
   logic          m_s;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   logic          m_bop;
   logic [31:0]   m_rdata;
   logic          m_e;

   task automatic model_resolve();
      int v;
      if (m_err) begin
         m_rdata = 32'd0;
         m_e     = 1'b1;
      end else if (m_w) begin
         m_rdata = 32'd0;
         m_e     = 1'b0;
      end else begin
         if (m_b) begin
            v = int'(read_data[7:0]);
            if (m_s && v >= 128) v = v - 256;
            m_rdata = 32'(v);
         end else begin
            m_rdata = read_data;
         end
         m_e = 1'b0;
      end
   endtask

   always @(posedge clk or posedge reset) begin
      int a;
      int last;
      if (reset) begin
         m_active = 1'b0;
         m_k      = 0;
         m_len    = 0;
         m_err    = 1'b0;
         m_addr   = '0;
         m_wdata  = '0;
         m_bop    = 1'b0;
         m_rdata  = '0;
         m_e      = 1'b0;
      end else if (m_active) begin
         if (m_k == m_len) begin
            m_active = 1'b0;
         end else begin
            m_k++;
            if (m_k == m_len) model_resolve();
         end
      end else if (req_valid) begin
         a     = int'(req_addr);
         last  = req_byte ? a : a + 3;
         m_w   = req_write;
         m_b   = req_byte;
         m_s   = req_signed;
         m_err = (last >= MB) || (!req_byte && (a % 4) != 0);
         m_len = m_err ? 1 : (req_write ? 3 + WH : 2 + RH);
         m_k   = 1;
         m_active = 1'b1;
         if (!m_err) begin
            m_addr  = req_addr;
            m_wdata = req_wdata;
            m_bop   = req_byte;
         end
         if (m_k == m_len) model_resolve();
      end
   end

   // Per-cycle compare, away from the active edge
   always @(negedge clk) begin
      logic exp_rd;
      logic exp_wr;
      if (reset) begin
         check("rst_req_ready", 32'(req_ready), 32'd1);
         check("rst_resp_valid", 32'(resp_valid), 32'd0);
         check("rst_resp_rdata", resp_rdata, 32'd0);
         check("rst_resp_error", 32'(resp_error), 32'd0);
         check("rst_memRead", 32'(memRead), 32'd0);
         check("rst_memWrite", 32'(memWrite), 32'd0);
         check("rst_address", 32'(address), 32'd0);
         check("rst_write_data", write_data, 32'd0);
         check("rst_byteOperations", 32'(byteOperations), 32'd0);
         check("rst_state", 32'(dbg_state), 32'(IDLE));
      end else begin
         exp_rd = m_active && !m_err && !m_w && (m_k >= 2) && (m_k <= 1 + RH);
         exp_wr = m_active && !m_err &&  m_w && (m_k >= 2) && (m_k <= 1 + WH);
         check("req_ready", 32'(req_ready), 32'(!m_active));
         check("resp_valid", 32'(resp_valid), 32'(m_active && m_k == m_len));
         check("memRead", 32'(memRead), 32'(exp_rd));
         check("memWrite", 32'(memWrite), 32'(exp_wr));
         check("strobe_exclusive", 32'(memRead && memWrite), 32'd0);
         if (m_active && !m_err) begin
            check("address", 32'(address), 32'(m_addr));
            check("write_data", write_data, m_wdata);
            check("byteOperations", 32'(byteOperations), 32'(m_bop));
         end
         if (m_active && m_k == m_len) begin
            check("resp_rdata", resp_rdata, m_rdata);
            check("resp_error", 32'(resp_error), 32'(m_e));
         end
      end
   end

   // Driver: presents one request in an IDLE cycle, waits for its response,
   // and returns in the following IDLE cycle.
   task automatic do_req(input logic w, input logic b, input logic s,
                         input logic [AW-1:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         output int lat, output logic [31:0] rdata, output logic err);
      req_valid  = 1'b1;
      req_write  = w;
      req_byte   = b;
      req_signed = s;
      req_addr   = a;
      req_wdata  = wd;
      read_data  = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) check("resp_timeout", 32'(lat), 32'd0);
      rdata = resp_rdata;
      err   = resp_error;
      @(posedge clk); #1;
   endtask

   initial begin
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          first_lat;
      int          second_lat;
      logic [31:0] second_rdata;

      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_byte   = 1'b0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      read_data  = '0;
      reset      = 1'b0;
      #1 reset   = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;

      // Word store, then word load of the same location
      do_req(1'b1, 1'b0, 1'b0, 18'h10, 32'hDEADBEEF, 32'h0, lat, rdata, err);
      check("store_latency", 32'(lat), 32'd4);
      check("store_error", 32'(err), 32'd0);
      do_req(1'b0, 1'b0, 1'b0, 18'h10, 32'h0, 32'hDEADBEEF, lat, rdata, err);
      check("load_latency", 32'(lat), 32'd3);
      check("load_word_rdata", rdata, 32'hDEADBEEF);

      // Byte loads, signed and unsigned
      do_req(1'b0, 1'b1, 1'b1, 18'h13, 32'h0, 32'h000000DE, lat, rdata, err);
      check("load_byte_signed", rdata, 32'hFFFFFFDE);
      do_req(1'b0, 1'b1, 1'b0, 18'h13, 32'h0, 32'h000000DE, lat, rdata, err);
      check("load_byte_unsigned", rdata, 32'h000000DE);

      // Illegal accesses and range boundaries
      do_req(1'b0, 1'b0, 1'b0, 18'h7E, 32'h0, 32'h55555555, lat, rdata, err);
      check("err_range_latency", 32'(lat), 32'd1);
      check("err_range_flag", 32'(err), 32'd1);
      check("err_range_rdata", rdata, 32'd0);
      do_req(1'b0, 1'b0, 1'b0, 18'h12, 32'h0, 32'h55555555, lat, rdata, err);
      check("err_align_flag", 32'(err), 32'd1);
      do_req(1'b0, 1'b1, 1'b1, 18'h7F, 32'h0, 32'h00000080, lat, rdata, err);
      check("byte_top_error", 32'(err), 32'd0);
      check("byte_top_rdata", rdata, 32'hFFFFFF80);
      do_req(1'b0, 1'b0, 1'b0, 18'h7C, 32'h0, 32'h12345678, lat, rdata, err);
      check("word_top_error", 32'(err), 32'd0);
      check("word_top_rdata", rdata, 32'h12345678);
      do_req(1'b0, 1'b1, 1'b0, 18'h80, 32'h0, 32'h0, lat, rdata, err);
      check("byte_past_end_error", 32'(err), 32'd1);
      do_req(1'b1, 1'b1, 1'b0, 18'h05, 32'h000000A5, 32'h0, lat, rdata, err);
      check("byte_store_latency", 32'(lat), 32'd4);
      check("byte_store_rdata", rdata, 32'd0);

      // req_valid held high while the fields change mid-operation
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_byte   = 1'b0;
      req_signed = 1'b0;
      req_addr   = 18'h20;
      req_wdata  = 32'h11223344;
      read_data  = 32'h0;
      first_lat    = 0;
      second_lat   = 0;
      second_rdata = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            check("busy_ready", 32'(req_ready), 32'd0);
            req_write  = 1'b0;
            req_byte   = 1'b1;
            req_addr   = 18'h21;
            req_wdata  = 32'h0;
            read_data  = 32'h000000AB;
         end
         if (c == 5) check("ready_after_resp", 32'(req_ready), 32'd1);
         if (c == 6) req_valid = 1'b0;
         if (resp_valid) begin
            if (first_lat == 0) begin
               first_lat = c;
            end else if (second_lat == 0) begin
               second_lat   = c;
               second_rdata = resp_rdata;
            end
         end
      end
      check("held_first_resp_cycle", 32'(first_lat), 32'd4);
      check("held_second_resp_cycle", 32'(second_lat), 32'd8);
      check("held_second_rdata", second_rdata, 32'h000000AB);

      // Reset asserted during the ACCESS cycle of a store
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_byte   = 1'b0;
      req_addr   = 18'h40;
      req_wdata  = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("midrst_memWrite_before", 32'(memWrite), 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_memWrite_async", 32'(memWrite), 32'd0);
      check("midrst_address_async", 32'(address), 32'd0);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("postrst_resp_valid", 32'(resp_valid), 32'd0);
         check("postrst_req_ready", 32'(req_ready), 32'd1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
